// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution, fetch redirect and pipeline flush
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            br_eq,
    input  logic            br_lt,
    output logic            brun_sel,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush_o,
    output logic            ex_stall,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_taken,
`endif
    output logic            illegal_br
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [XLEN-1:0] redirect_pc_nxt;
    logic            illegal_nxt;

    logic            sel_jalr, sel_jal, sel_br;
    logic            br_cond, reserved_f3, taken;
    logic [XLEN-1:0] jalr_sum, target;

    assign brun_sel = (ex_funct3[2:1] == 2'b11);

    // Instruction class with JALR > JAL > branch priority.
    assign sel_jalr = ex_is_jalr;
    assign sel_jal  = !ex_is_jalr && ex_is_jal;
    assign sel_br   = !ex_is_jalr && !ex_is_jal && ex_is_branch;

    assign reserved_f3 = (ex_funct3[2:1] == 2'b01);

    always_comb begin
        br_cond = 1'b0;
        case (ex_funct3)
            3'b000:         br_cond = br_eq;
            3'b001:         br_cond = !br_eq;
            3'b100, 3'b110: br_cond = br_lt;
            3'b101, 3'b111: br_cond = !br_lt;
            default:        br_cond = 1'b0;
        endcase
    end

    assign taken    = sel_jalr || sel_jal || (sel_br && br_cond);
    assign jalr_sum = ex_rs1 + ex_imm;
    assign target   = sel_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        redirect_pc_nxt = redirect_pc;
        illegal_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    illegal_nxt = sel_br && reserved_f3;
                    if (taken) begin
                        redirect_pc_nxt = target;
                        state_nxt       = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            redirect_pc <= '0;
            illegal_br  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            redirect_pc <= redirect_pc_nxt;
            illegal_br  <= illegal_nxt;
        end
    end

    assign redirect_valid = (state == REDIRECT);
    assign flush_o        = (state == FLUSH);
    assign ex_stall       = (state != IDLE);

`ifdef BRANCH_STATS_EN
    logic resolve_evt, taken_evt;

    assign resolve_evt = (state == IDLE) && ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
    assign taken_evt   = (state == IDLE) && (state_nxt == REDIRECT);

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_taken    <= '0;
        end else begin
            if (resolve_evt && (stat_resolved != 32'hFFFF_FFFF)) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (taken_evt && (stat_taken != 32'hFFFF_FFFF)) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1;
    logic            br_eq, br_lt;
    logic            brun_sel, redirect_valid, redirect_ready, flush_o, ex_stall, illegal_br;
    logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_resolved, stat_taken;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .br_eq          (br_eq),
        .br_lt          (br_lt),
        .brun_sel       (brun_sel),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_o        (flush_o),
        .ex_stall       (ex_stall),
`ifdef BRANCH_STATS_EN
        .stat_resolved  (stat_resolved),
        .stat_taken     (stat_taken),
`endif
        .illegal_br     (illegal_br)
    );

    typedef struct {
        logic        valid;
        logic        isb;
        logic        isjal;
        logic        isjalr;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        eq;
        logic        lt;
        int          delay;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[15];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_res = 0;
    int   exp_tak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from IDLE and follow it until the unit is idle again.
    task automatic run_txn(input vec_t v);
        ex_valid     = v.valid;
        ex_is_branch = v.isb;
        ex_is_jal    = v.isjal;
        ex_is_jalr   = v.isjalr;
        ex_funct3    = v.f3;
        ex_pc        = v.pc;
        ex_imm       = v.imm;
        ex_rs1       = v.rs1;
        br_eq        = v.eq;
        br_lt        = v.lt;
        redirect_ready = 1'b1;
        #1;
        chk("brun_sel", 32'(brun_sel), 32'(v.f3 == 3'd6 || v.f3 == 3'd7));
        chk("idle_stall", 32'(ex_stall), 32'd0);
        if (v.valid && (v.isb || v.isjal || v.isjalr)) exp_res++;
        if (v.exp_taken) exp_tak++;
        step();
        ex_valid = 1'b0;
        chk("illegal_br", 32'(illegal_br), 32'(v.exp_ill));
        if (v.exp_taken) begin
            for (int i = 0; i <= v.delay; i++) begin
                redirect_ready = (i == v.delay);
                chk("redir_valid", 32'(redirect_valid), 32'd1);
                chk("redir_pc", redirect_pc, v.exp_pc);
                chk("redir_stall", 32'(ex_stall), 32'd1);
                chk("redir_noflush", 32'(flush_o), 32'd0);
                step();
            end
            redirect_ready = 1'b0;
            for (int j = 0; j < FC; j++) begin
                chk("flush_hi", 32'(flush_o), 32'd1);
                chk("flush_stall", 32'(ex_stall), 32'd1);
                chk("flush_novalid", 32'(redirect_valid), 32'd0);
                step();
            end
            chk("end_flush", 32'(flush_o), 32'd0);
            chk("end_stall", 32'(ex_stall), 32'd0);
        end else begin
            chk("nt_valid", 32'(redirect_valid), 32'd0);
            chk("nt_stall", 32'(ex_stall), 32'd0);
            chk("nt_flush", 32'(flush_o), 32'd0);
            step();
            chk("ill_pulse_end", 32'(illegal_br), 32'd0);
        end
        chk("idle_valid", 32'(redirect_valid), 32'd0);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] a, b;
        int          kind;
        bit          t;

        //          valid isb jal jalr f3      pc            imm           rs1          eq lt dly tk  exp_pc        ill
        vecs[0]  = '{1, 1, 0, 0, 3'b000, 32'h100,      32'h20,       32'h0,       1, 0, 0, 1, 32'h120,      0};
        vecs[1]  = '{1, 1, 0, 0, 3'b000, 32'h100,      32'h20,       32'h0,       0, 0, 0, 0, 32'h0,        0};
        vecs[2]  = '{1, 1, 0, 0, 3'b001, 32'h1000,     32'hFFFFFFF0, 32'h0,       0, 0, 1, 1, 32'hFF0,      0};
        vecs[3]  = '{1, 1, 0, 0, 3'b100, 32'h300,      32'h8,        32'h0,       0, 1, 0, 1, 32'h308,      0};
        vecs[4]  = '{1, 1, 0, 0, 3'b101, 32'h300,      32'h8,        32'h0,       0, 1, 0, 0, 32'h0,        0};
        vecs[5]  = '{1, 1, 0, 0, 3'b110, 32'h400,      32'h10,       32'h0,       0, 0, 0, 0, 32'h0,        0};
        vecs[6]  = '{1, 1, 0, 0, 3'b111, 32'hFFFFFFF0, 32'h20,       32'h0,       0, 0, 2, 1, 32'h10,       0};
        vecs[7]  = '{1, 0, 1, 0, 3'b000, 32'h200,      32'h40,       32'h0,       0, 0, 3, 1, 32'h240,      0};
        vecs[8]  = '{1, 0, 0, 1, 3'b000, 32'h500,      32'h2,        32'h1003,    0, 0, 0, 1, 32'h1004,     0};
        vecs[9]  = '{1, 1, 0, 0, 3'b010, 32'h600,      32'h8,        32'h0,       1, 1, 0, 0, 32'h0,        1};
        vecs[10] = '{1, 1, 0, 0, 3'b011, 32'h600,      32'h8,        32'h0,       1, 0, 0, 0, 32'h0,        1};
        vecs[11] = '{1, 1, 1, 1, 3'b000, 32'h900,      32'h11,       32'h80,      0, 0, 0, 1, 32'h90,       0};
        vecs[12] = '{1, 1, 1, 0, 3'b010, 32'h40,       32'h4,        32'h0,       0, 0, 1, 1, 32'h44,       0};
        vecs[13] = '{0, 0, 1, 0, 3'b000, 32'h700,      32'h4,        32'h0,       0, 0, 0, 0, 32'h0,        0};
        vecs[14] = '{1, 0, 0, 0, 3'b000, 32'h700,      32'h4,        32'h0,       1, 0, 0, 0, 32'h0,        0};

        rst_n = 1'b0;
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
        br_eq = 0; br_lt = 0; redirect_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(redirect_valid), 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        chk("rst_illegal", 32'(illegal_br), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) run_txn(vecs[i]);

        // Random branches driven through a comparator model on real operands.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            v.valid  = 1'b1;
            v.isb    = (kind <= 5);
            v.isjal  = (kind == 6 || kind == 7);
            v.isjalr = (kind >= 8);
            case ($urandom_range(0, 7))
                0: v.f3 = 3'd0; 1: v.f3 = 3'd1; 2: v.f3 = 3'd4; 3: v.f3 = 3'd5;
                4: v.f3 = 3'd6; 5: v.f3 = 3'd7; 6: v.f3 = 3'd2; default: v.f3 = 3'd3;
            endcase
            v.pc    = $urandom & 32'hFFFF_FFFC;
            v.imm   = $urandom;
            v.rs1   = $urandom;
            v.delay = int'($urandom_range(0, 3));
            ex_funct3 = v.f3;
            #1;
            v.eq = (a == b);
            v.lt = brun_sel ? (a < b) : ($signed(a) < $signed(b));
            case (v.f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = ($signed(a) >= $signed(b));
                3'd6: t = (a < b);
                3'd7: t = (a >= b);
                default: t = 1'b0;
            endcase
            v.exp_taken = v.isjal || v.isjalr || t;
            v.exp_pc    = v.isjalr ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
            v.exp_ill   = v.isb && (v.f3 == 3'd2 || v.f3 == 3'd3);
            run_txn(v);
        end

`ifdef BRANCH_STATS_EN
        chk("stat_resolved", stat_resolved, 32'(exp_res));
        chk("stat_taken", stat_taken, 32'(exp_tak));
`endif

        // Asynchronous reset in the middle of FLUSH.
        ex_valid = 1; ex_is_branch = 0; ex_is_jal = 1; ex_is_jalr = 0;
        ex_pc = 32'h800; ex_imm = 32'h10; redirect_ready = 1;
        step();
        ex_valid = 0;
        step();
        chk("pre_rst_flush", 32'(flush_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush_o), 32'd0);
        chk("arst_stall", 32'(ex_stall), 32'd0);
        chk("arst_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_stall", 32'(ex_stall), 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rst_stat_res", stat_resolved, 32'd0);
        chk("rst_stat_tak", stat_taken, 32'd0);
`endif

        // Asynchronous reset while a redirect is pending drops it.
        ex_valid = 1; redirect_ready = 0;
        step();
        ex_valid = 0;
        chk("pend_valid", 32'(redirect_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("drop_valid", 32'(redirect_valid), 32'd0);
        chk("drop_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        redirect_ready = 1;
        step();
        step();
        chk("dropped_valid", 32'(redirect_valid), 32'd0);
        chk("dropped_flush", 32'(flush_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
